// File: rtl/rom_fetch_bridge.sv
// ============================================================================
// Module   : rom_fetch_bridge
// Purpose  : Turns level-style mapper ROM strobes into single req/ack SDRAM
//            reads with address masking, byte-lane select and data hold.
//            Optional one-word prefetch buffer: define ROM_PREFETCH_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rom_fetch_bridge #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 16
) (
    input  logic              mclk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rom_addr,
    input  logic              rom_ce_n,
    input  logic              rom_oe_n,
    input  logic              rom_word,
    input  logic [ADDR_W-1:0] rom_mask,
    output logic [DATA_W-1:0] rom_q,
    output logic              rom_busy,
    output logic              mem_req,
    output logic [ADDR_W-2:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;
`ifdef ROM_PREFETCH_EN
    localparam logic [1:0] ST_PF_REQ = 2'd3;
`endif

    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_mask;
    logic              r_ce_n;
    logic              r_oe_n;
    logic              r_word;
    logic              r_active_d;

    logic [1:0]        r_state;
    logic [ADDR_W:0]   r_key;
    logic [ADDR_W:0]   r_last_key;
    logic              r_last_vld;
    logic [DATA_W-1:0] r_data;
    logic              r_pending;
    logic              r_reeval;

    logic              w_active;
    logic              w_rose;
    logic [ADDR_W-1:0] w_maddr;
    logic [ADDR_W-2:0] w_word;
    logic [ADDR_W:0]   w_key;
    logic              w_new;
    logic              w_demand;
    logic              w_chg;
    logic [DATA_W/2-1:0] w_byte;
    logic [DATA_W-1:0] w_lane;

`ifdef ROM_PREFETCH_EN
    logic [ADDR_W-2:0] r_pf_addr;
    logic [DATA_W-1:0] r_pf_data;
    logic              r_pf_vld;
    logic              r_pf_stale;
    logic [ADDR_W-2:0] w_pf_word;
    logic              w_mask_chg;
`endif

    // Input stage S0: all mapper-side signals registered once
    always_ff @(posedge mclk) begin
        if (!rst_n) begin
            r_addr     <= '0;
            r_mask     <= '0;
            r_ce_n     <= 1'b1;
            r_oe_n     <= 1'b1;
            r_word     <= 1'b0;
            r_active_d <= 1'b0;
        end else begin
            r_addr     <= rom_addr;
            r_mask     <= rom_mask;
            r_ce_n     <= rom_ce_n;
            r_oe_n     <= rom_oe_n;
            r_word     <= rom_word;
            r_active_d <= w_active;
        end
    end

    assign w_active = ~r_ce_n & ~r_oe_n;
    assign w_rose   = w_active & ~r_active_d;
    assign w_maddr  = r_addr & r_mask;
    assign w_word   = w_maddr[ADDR_W-1:1];
    assign w_key    = {w_maddr, r_word};
    assign w_new    = w_active & (~r_last_vld | (w_key != r_last_key) | w_rose);
    assign w_demand = w_new | (w_active & r_reeval);
    // Anything the in-flight transfer will not satisfy
    assign w_chg    = w_active & ((w_key != r_key) | w_rose);

    // Key bit 0 is the word flag, bit 1 is byte-address bit 0
    assign w_byte   = r_key[1] ? r_data[DATA_W-1:DATA_W/2] : r_data[DATA_W/2-1:0];
    assign w_lane   = r_key[0] ? r_data : {w_byte, w_byte};

`ifdef ROM_PREFETCH_EN
    assign w_pf_word  = (r_key[ADDR_W:2] + 1'b1) & r_mask[ADDR_W-1:1];
    assign w_mask_chg = (rom_mask != r_mask);
`endif

    always_ff @(posedge mclk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            rom_q      <= '0;
            rom_busy   <= 1'b0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            r_key      <= '0;
            r_last_key <= '0;
            r_last_vld <= 1'b0;
            r_data     <= '0;
            r_pending  <= 1'b0;
            r_reeval   <= 1'b0;
`ifdef ROM_PREFETCH_EN
            r_pf_addr  <= '0;
            r_pf_data  <= '0;
            r_pf_vld   <= 1'b0;
            r_pf_stale <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_reeval <= 1'b0;
                    if (w_demand) begin
                        r_key     <= w_key;
                        r_pending <= 1'b0;
                        rom_busy  <= 1'b1;
`ifdef ROM_PREFETCH_EN
                        if (r_pf_vld && (w_word == r_pf_addr)) begin
                            r_data  <= r_pf_data;
                            r_state <= ST_DONE;
                        end else begin
                            r_pf_vld <= 1'b0;
                            mem_addr <= w_word;
                            mem_req  <= 1'b1;
                            r_state  <= ST_WAIT;
                        end
`else
                        mem_addr <= w_word;
                        mem_req  <= 1'b1;
                        r_state  <= ST_WAIT;
`endif
                    end
                end
                ST_WAIT: begin
                    if (w_chg) begin
                        r_pending <= 1'b1;
                    end
                    if (mem_ack) begin
                        r_data  <= mem_dout;
                        mem_req <= 1'b0;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    rom_q      <= w_lane;
                    rom_busy   <= 1'b0;
                    r_last_key <= r_key;
                    r_last_vld <= 1'b1;
                    r_pending  <= 1'b0;
                    if (r_pending || w_chg) begin
                        r_reeval <= 1'b1;
                        r_state  <= ST_IDLE;
                    end else begin
`ifdef ROM_PREFETCH_EN
                        mem_addr   <= w_pf_word;
                        mem_req    <= 1'b1;
                        r_pf_addr  <= w_pf_word;
                        r_pf_vld   <= 1'b0;
                        r_pf_stale <= 1'b0;
                        r_state    <= ST_PF_REQ;
`else
                        r_state    <= ST_IDLE;
`endif
                    end
                end
`ifdef ROM_PREFETCH_EN
                ST_PF_REQ: begin
                    if (w_new) begin
                        r_pending <= 1'b1;
                    end
                    if (w_mask_chg) begin
                        r_pf_stale <= 1'b1;
                    end
                    if (mem_ack) begin
                        r_pf_data <= mem_dout;
                        r_pf_vld  <= ~(r_pf_stale | w_mask_chg);
                        mem_req   <= 1'b0;
                        r_reeval  <= r_pending | w_new;
                        r_pending <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
`endif
                default: r_state <= ST_IDLE;
            endcase
`ifdef ROM_PREFETCH_EN
            // A mask change reshapes the address space under the buffer
            if (w_mask_chg && (r_state != ST_PF_REQ)) begin
                r_pf_vld <= 1'b0;
            end
`endif
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rom_fetch_bridge.sv
// ============================================================================
// Module   : tb_rom_fetch_bridge
// Purpose  : Self-checking bench for rom_fetch_bridge with an SDRAM responder
//            and an address/lane reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rom_fetch_bridge;

    logic        mclk = 1'b0;
    logic        rst_n;
    logic [23:0] rom_addr;
    logic        rom_ce_n;
    logic        rom_oe_n;
    logic        rom_word;
    logic [23:0] rom_mask;
    logic [15:0] rom_q;
    logic        rom_busy;
    logic        mem_req;
    logic [22:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_dout;

    logic [15:0] mem [0:255];
    int          resp_lat   = 0;
    int          force_req  = 0;
    int          force_seen = 0;
    int          wcnt       = 0;
    int          nreq       = 0;
    logic        req_prev   = 1'b0;
    int          errors     = 0;
    int          checks     = 0;

    always #5 mclk = ~mclk;

    rom_fetch_bridge #(.ADDR_W(24), .DATA_W(16)) dut (
        .mclk     (mclk),
        .rst_n    (rst_n),
        .rom_addr (rom_addr),
        .rom_ce_n (rom_ce_n),
        .rom_oe_n (rom_oe_n),
        .rom_word (rom_word),
        .rom_mask (rom_mask),
        .rom_q    (rom_q),
        .rom_busy (rom_busy),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_ack  (mem_ack),
        .mem_dout (mem_dout)
    );

    // SDRAM responder: ack after resp_lat extra cycles of mem_req
    initial begin
        mem_ack  = 1'b0;
        mem_dout = '0;
        forever begin
            @(negedge mclk);
            mem_ack = 1'b0;
            if (force_req != force_seen) begin
                force_seen = force_req;
                mem_ack    = 1'b1;
                mem_dout   = 16'hDEAD;
            end else if (rst_n && mem_req) begin
                if (wcnt >= resp_lat) begin
                    mem_ack  = 1'b1;
                    mem_dout = mem[mem_addr[7:0]];
                    wcnt     = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // Demand-request counter (prefetch requests leave rom_busy low)
    initial begin
        forever begin
            @(posedge mclk);
            #1;
            if (mem_req && !req_prev && rom_busy) nreq++;
            req_prev = mem_req;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] exp_q(input logic [23:0] a, input logic w,
                                          input logic [23:0] m);
        logic [23:0] ma;
        logic [15:0] d;
        ma = a & m;
        d  = mem[ma[8:1]];
        if (w) return d;
        return ma[0] ? {d[15:8], d[15:8]} : {d[7:0], d[7:0]};
    endfunction

    function automatic logic [22:0] exp_addr(input logic [23:0] a, input logic [23:0] m);
        logic [23:0] ma;
        ma = a & m;
        return ma[23:1];
    endfunction

    task automatic go_idle(input int n);
        @(negedge mclk);
        rom_ce_n = 1'b1;
        rom_oe_n = 1'b1;
        repeat (n) @(negedge mclk);
        for (int i = 0; i < 100 && mem_req; i++) @(negedge mclk);
        if (mem_req) begin
            errors++;
            checks++;
            $display("FAIL idle_timeout: mem_req=%0b required 0", mem_req);
        end
    endtask

    // Drive one strobe and observe; cyc is cycles from registered strobe to rom_q
    task automatic issue_read(input logic [23:0] a, input logic w, input logic [23:0] m,
                              input int lat, output int cyc, output logic [22:0] seen,
                              output logic [15:0] q_before);
        logic busy_prev;
        logic got;
        resp_lat = lat;
        @(negedge mclk);
        rom_addr  = a;
        rom_word  = w;
        rom_mask  = m;
        rom_ce_n  = 1'b0;
        rom_oe_n  = 1'b0;
        cyc       = -1;
        seen      = '1;
        got       = 1'b0;
        busy_prev = 1'b0;
        q_before  = rom_q;
        for (int i = 1; i <= 60; i++) begin
            @(negedge mclk);
            if (mem_req && rom_busy && !got) begin
                seen = mem_addr;
                got  = 1'b1;
            end
            if (busy_prev && !rom_busy) begin
                cyc = i - 1;
                break;
            end
            busy_prev = rom_busy;
            q_before  = rom_q;
        end
        if (cyc < 0) begin
            errors++;
            checks++;
            $display("FAIL read_timeout: addr=%h busy never completed", a);
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        rom_addr = '0;
        rom_word = 1'b0;
        rom_mask = 24'h0FFFFF;
        rom_ce_n = 1'b1;
        rom_oe_n = 1'b1;
        repeat (3) @(negedge mclk);
        rst_n = 1'b1;
        @(negedge mclk);
        checks++; if (rom_q !== 16'h0)    begin errors++; $display("FAIL reset_rom_q: got %h required 0000", rom_q); end
        checks++; if (rom_busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b required 0", rom_busy); end
        checks++; if (mem_req !== 1'b0)   begin errors++; $display("FAIL reset_req: got %b required 0", mem_req); end
        checks++; if (mem_addr !== 23'h0) begin errors++; $display("FAIL reset_addr: got %h required 0", mem_addr); end
    endtask

    task automatic test_word_read();
        int cyc; logic [22:0] seen; logic [15:0] qb; int n0;
        mem[8'h80] = 16'hBEEF;
        n0 = nreq;
        issue_read(24'h000100, 1'b1, 24'h0FFFFF, 4, cyc, seen, qb);
        checks++; if (seen !== 23'h000080) begin errors++; $display("FAIL word_addr: got %h required 000080", seen); end
        checks++; if (cyc != 7)            begin errors++; $display("FAIL word_latency: got %0d required 7", cyc); end
        checks++; if (rom_q !== 16'hBEEF)  begin errors++; $display("FAIL word_q: got %h required beef", rom_q); end
        checks++; if (qb !== 16'h0000)     begin errors++; $display("FAIL word_q_early: got %h required 0000", qb); end
        checks++; if (rom_busy !== 1'b0)   begin errors++; $display("FAIL word_busy: got %b required 0", rom_busy); end
        checks++; if (nreq - n0 != 1)      begin errors++; $display("FAIL word_nreq: got %0d required 1", nreq - n0); end
        go_idle(12);
    endtask

    task automatic test_byte_lanes();
        int cyc; logic [22:0] seen; logic [15:0] qb;
        mem[8'h80] = 16'h12AB;
        issue_read(24'h000101, 1'b0, 24'h0FFFFF, 1, cyc, seen, qb);
        checks++; if (rom_q !== 16'h1212) begin errors++; $display("FAIL byte_hi: got %h required 1212", rom_q); end
        go_idle(12);
        issue_read(24'h000100, 1'b0, 24'h0FFFFF, 0, cyc, seen, qb);
        checks++; if (rom_q !== 16'hABAB) begin errors++; $display("FAIL byte_lo: got %h required abab", rom_q); end
        checks++; if (cyc != 3)           begin errors++; $display("FAIL byte_min_latency: got %0d required 3", cyc); end
        go_idle(12);
    endtask

    task automatic test_mask_wrap();
        int cyc; logic [22:0] seen; logic [15:0] qb; int n0; logic [15:0] eq;
        mem[8'h00] = 16'h5A3C;
        eq = exp_q(24'h300000, 1'b1, 24'h0FFFFF);
        n0 = nreq;
        issue_read(24'h300000, 1'b1, 24'h0FFFFF, 2, cyc, seen, qb);
        checks++; if (seen !== 23'h0) begin errors++; $display("FAIL mask_addr: got %h required 000000", seen); end
        checks++; if (rom_q !== eq)   begin errors++; $display("FAIL mask_q: got %h required %h", rom_q, eq); end
        repeat (20) @(negedge mclk);
        checks++; if (nreq - n0 != 1) begin errors++; $display("FAIL hold_nreq: got %0d required 1", nreq - n0); end
        checks++; if (rom_q !== eq)   begin errors++; $display("FAIL hold_q: got %h required %h", rom_q, eq); end
        go_idle(12);
    endtask

    task automatic test_change_during_wait();
        int n0, falls; logic bp, rp; logic [15:0] q1; logic [22:0] a2; logic [15:0] eq2;
        mem[8'h80] = 16'h1111;
        mem[8'h00] = 16'h2222;
        eq2 = exp_q(24'h000200, 1'b1, 24'h0FFFFF);
        n0 = nreq; falls = 0; bp = 1'b0; rp = 1'b0; q1 = '0; a2 = '1;
        resp_lat = 5;
        @(negedge mclk);
        rom_addr = 24'h000100; rom_word = 1'b1; rom_mask = 24'h0FFFFF;
        rom_ce_n = 1'b0; rom_oe_n = 1'b0;
        repeat (3) @(negedge mclk);
        rom_addr = 24'h000200;
        for (int i = 0; i < 80 && falls < 2; i++) begin
            @(negedge mclk);
            if (falls == 1 && mem_req && !rp && rom_busy) a2 = mem_addr;
            if (bp && !rom_busy) begin
                falls++;
                if (falls == 1) q1 = rom_q;
            end
            bp = rom_busy;
            rp = mem_req;
        end
        checks++; if (falls != 2)        begin errors++; $display("FAIL chg_complete: got %0d completions required 2", falls); end
        checks++; if (q1 !== 16'h1111)   begin errors++; $display("FAIL chg_stale_q: got %h required 1111", q1); end
        checks++; if (a2 !== 23'h000100) begin errors++; $display("FAIL chg_addr2: got %h required 000100", a2); end
        checks++; if (rom_q !== eq2)     begin errors++; $display("FAIL chg_final_q: got %h required %h", rom_q, eq2); end
        checks++; if (nreq - n0 != 2)    begin errors++; $display("FAIL chg_nreq: got %0d required 2", nreq - n0); end
        go_idle(12);
    endtask

`ifdef ROM_PREFETCH_EN
    task automatic test_prefetch();
        int cyc; logic [22:0] seen; logic [15:0] qb; int n0; logic [15:0] eq;
        issue_read(24'h000100, 1'b1, 24'h0FFFFF, 2, cyc, seen, qb);
        go_idle(15);
        n0 = nreq;
        eq = exp_q(24'h000102, 1'b1, 24'h0FFFFF);
        issue_read(24'h000102, 1'b1, 24'h0FFFFF, 2, cyc, seen, qb);
        checks++; if (nreq != n0)   begin errors++; $display("FAIL pf_hit_nreq: got %0d required 0", nreq - n0); end
        checks++; if (cyc != 2)     begin errors++; $display("FAIL pf_hit_latency: got %0d required 2", cyc); end
        checks++; if (rom_q !== eq) begin errors++; $display("FAIL pf_hit_q: got %h required %h", rom_q, eq); end
        go_idle(15);
        n0 = nreq;
        issue_read(24'h000400, 1'b1, 24'h0FFFFF, 2, cyc, seen, qb);
        checks++; if (nreq - n0 != 1) begin errors++; $display("FAIL pf_miss_nreq: got %0d required 1", nreq - n0); end
        checks++; if (cyc != 5)       begin errors++; $display("FAIL pf_miss_latency: got %0d required 5", cyc); end
        go_idle(15);
        n0 = nreq;
        issue_read(24'h000402, 1'b1, 24'h07FFFF, 1, cyc, seen, qb);
        checks++; if (nreq - n0 != 1) begin errors++; $display("FAIL pf_maskchg_nreq: got %0d required 1", nreq - n0); end
        checks++; if (cyc != 4)       begin errors++; $display("FAIL pf_maskchg_latency: got %0d required 4", cyc); end
        go_idle(15);
    endtask
`endif

    task automatic test_random();
        logic [23:0] masks [4];
        logic [23:0] a, m, prev_m;
        logic [22:0] seen, wa, prev_wa;
        logic [15:0] qb, eq;
        logic        w, hit, prev_vld;
        int          cyc, lat, n0;
        masks[0] = 24'h0FFFFF; masks[1] = 24'h3FFFFF;
        masks[2] = 24'h07FFFF; masks[3] = 24'hFFFFFF;
        prev_vld = 1'b0; prev_wa = '0; prev_m = '0;
        for (int k = 0; k < 24; k++) begin
            a   = 24'($urandom);
            w   = 1'($urandom_range(0, 1));
            m   = masks[$urandom_range(0, 3)];
            lat = $urandom_range(0, 5);
            wa  = exp_addr(a, m);
            eq  = exp_q(a, w, m);
            hit = 1'b0;
`ifdef ROM_PREFETCH_EN
            hit = prev_vld && (m == prev_m) && (wa == ((prev_wa + 23'd1) & m[23:1]));
`endif
            n0 = nreq;
            issue_read(a, w, m, lat, cyc, seen, qb);
            checks++; if (rom_q !== eq) begin errors++; $display("FAIL rand_q[%0d]: addr=%h word=%b got %h required %h", k, a, w, rom_q, eq); end
            checks++; if (cyc != (hit ? 2 : 3 + lat)) begin errors++; $display("FAIL rand_latency[%0d]: got %0d required %0d", k, cyc, hit ? 2 : 3 + lat); end
            if (!hit) begin
                checks++; if (seen !== wa) begin errors++; $display("FAIL rand_addr[%0d]: got %h required %h", k, seen, wa); end
            end
            checks++; if (nreq - n0 != (hit ? 0 : 1)) begin errors++; $display("FAIL rand_nreq[%0d]: got %0d required %0d", k, nreq - n0, hit ? 0 : 1); end
            prev_vld = 1'b1; prev_wa = wa; prev_m = m;
            go_idle(15);
        end
    endtask

    task automatic test_reset_mid_wait();
        int n0;
        n0 = nreq;
        resp_lat = 20;
        @(negedge mclk);
        rom_addr = 24'h000100; rom_word = 1'b1; rom_mask = 24'h0FFFFF;
        rom_ce_n = 1'b0; rom_oe_n = 1'b0;
        for (int i = 0; i < 10 && !mem_req; i++) @(negedge mclk);
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_wait_entry: mem_req=%b required 1", mem_req); end
        rst_n = 1'b0; rom_ce_n = 1'b1; rom_oe_n = 1'b1;
        @(negedge mclk);
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_req_drop: got %b required 0", mem_req); end
        rst_n = 1'b1;
        @(negedge mclk);
        force_req++;
        repeat (10) @(negedge mclk);
        checks++; if (rom_q !== 16'h0)   begin errors++; $display("FAIL rst_rom_q: got %h required 0000", rom_q); end
        checks++; if (rom_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b required 0", rom_busy); end
        checks++; if (mem_req !== 1'b0)  begin errors++; $display("FAIL rst_no_req: got %b required 0", mem_req); end
        checks++; if (nreq - n0 != 1)    begin errors++; $display("FAIL rst_nreq: got %0d required 1", nreq - n0); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        test_reset();
        test_word_read();
        test_byte_lanes();
        test_mask_wrap();
        test_change_during_wait();
`ifdef ROM_PREFETCH_EN
        test_prefetch();
`endif
        test_random();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
